rst_gen: RTL

RST_GEN -- requirements
Module: rst_gen

---
 rtl/rst_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/rst_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rst_pkg.sv
// -----------------------------------------------------------------------------
// rst_pkg
// Shared types for the reset generator: FSM state encoding, reset-cause
// encodings reported on rst_cause, counter widths, and the cause priority
// helper used when several reset events arrive in the same cycle.
// -----------------------------------------------------------------------------
package rst_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_BTN = 2'd1,
    CAUSE_SW  = 2'd2,
    CAUSE_WDT = 2'd3
  } cause_e;

  localparam int HOLD_CNT_W = 16;
  localparam int DEB_CNT_W  = 16;
  localparam int WDT_CNT_W  = 24;

  // Priority BTN > SW > WDT; only called when at least one event is present.
  function automatic cause_e pick_cause(input logic btn, input logic sw);
    if (btn) begin
      return CAUSE_BTN;
    end else if (sw) begin
      return CAUSE_SW;
    end else begin
      return CAUSE_WDT;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Brings the asynchronous pushbutton into the clk domain with a 2-flop
// synchronizer and debounces it. The debounced level follows the synchronized
// input only after the input has differed from the level for DEBOUNCE_CYC
// consecutive cycles; any bounce back restarts the count.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (already synchronized upstream)
//   btn_n  in   raw button, low = pressed, asynchronous to clk
//   level  out  debounced button level (1 = released)
//   press  out  one-cycle pulse on the debounced 1->0 transition
// -----------------------------------------------------------------------------
module btn_debounce
  import rst_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]           r_sync;
  logic                 r_level;
  logic                 r_press;
  logic [DEB_CNT_W-1:0] r_stab_cnt;
  logic                 w_btn_sync;

  assign w_btn_sync = r_sync[1];

  // Synchronizer, stability counter and debounced level/press registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b11;
      r_level    <= 1'b1;
      r_press    <= 1'b0;
      r_stab_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[0], btn_n};
      r_press <= 1'b0;
      if (w_btn_sync == r_level) begin
        // Input agrees with the level (or bounced back): nothing pending.
        r_stab_cnt <= '0;
      end else if (r_stab_cnt == DEB_LAST) begin
        // This is the DEBOUNCE_CYC-th consecutive differing cycle.
        r_level    <= w_btn_sync;
        r_press    <= ~w_btn_sync;
        r_stab_cnt <= '0;
      end else begin
        r_stab_cnt <= r_stab_cnt + DEB_CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/rst_gen.sv
// -----------------------------------------------------------------------------
// rst_gen
// Stretched reset generator. Collects reset events (debounced button press,
// software request, watchdog expiry), records the cause, and holds the
// downstream reset low for HOLD_CYC cycles per event. A held button keeps the
// reset asserted until HOLD_CYC cycles after its debounced release.
//
// rst_out_n is a registered copy of the FSM state, so it trails the FSM by one
// cycle: an event sampled at edge k moves the FSM to HOLD at edge k and pulls
// rst_out_n low at edge k+1; after power-on reset release rst_out_n rises
// HOLD_CYC+2 cycles after the first edge that samples rst_n high.
//
// Ports
//   clk         in   system clock, all outputs registered on its rising edge
//   rst_n       in   asynchronous active-low reset (internally synchronized)
//   btn_n       in   raw pushbutton, low = pressed
//   sw_rst_req  in   single-cycle software reset request
//   wdt_en      in   watchdog enable
//   wdt_kick    in   watchdog restart pulse
//   rst_out_n   out  stretched active-low reset
//   rst_cause   out  cause of last reset: 0 POR, 1 BTN, 2 SW, 3 WDT
//   wdt_cnt     out  current watchdog count (debug)
// -----------------------------------------------------------------------------
module rst_gen
  import rst_pkg::*;
#(
  parameter int HOLD_CYC     = 256,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int WDT_CYC      = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_n,
  input  logic                 sw_rst_req,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  output logic                 rst_out_n,
  output logic [1:0]           rst_cause,
  output logic [WDT_CNT_W-1:0] wdt_cnt
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYC - 1);
  localparam logic [WDT_CNT_W-1:0]  WDT_LAST  = WDT_CNT_W'(WDT_CYC - 1);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_int_n;
  state_e                r_state;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  cause_e                r_cause;
  logic                  r_rst_out_n;
  logic [WDT_CNT_W-1:0]  r_wdt_cnt;
  logic                  w_btn_level;
  logic                  w_btn_press;
  logic                  w_btn_evt;
  logic                  w_sw_evt;
  logic                  w_wdt_exp;
  logic                  w_evt;

  // Reset synchronizer: asserts asynchronously, releases on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_int_n = r_rst_sync[1];

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(w_rst_int_n),
    .btn_n(btn_n),
    .level(w_btn_level),
    .press(w_btn_press)
  );

  // Events are only acted on in RUN; in HOLD they are ignored.
  assign w_btn_evt = (r_state == RUN) && w_btn_press;
  assign w_sw_evt  = (r_state == RUN) && sw_rst_req;
  // A kick in the expiry cycle wins, so no expiry when wdt_kick is high.
  assign w_wdt_exp = (r_state == RUN) && wdt_en && !wdt_kick && (r_wdt_cnt == WDT_LAST);
  assign w_evt     = w_btn_evt || w_sw_evt || w_wdt_exp;

  // Reset FSM with hold counter, cause register and registered rst_out_n.
  always_ff @(posedge clk or negedge w_rst_int_n) begin
    if (!w_rst_int_n) begin
      r_state     <= HOLD;
      r_hold_cnt  <= '0;
      r_cause     <= CAUSE_POR;
      r_rst_out_n <= 1'b0;
    end else begin
      r_rst_out_n <= (r_state == RUN);
      case (r_state)
        HOLD: begin
          if (!w_btn_level) begin
            // Button still held: keep restarting the hold period.
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= RUN;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
          end
        end
        RUN: begin
          if (w_evt) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
            r_cause    <= pick_cause(w_btn_evt, w_sw_evt);
          end else begin
            r_hold_cnt <= '0;
          end
        end
        default: begin
          r_state    <= HOLD;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  // Watchdog counter; any event clears it since the next cycle is HOLD.
  always_ff @(posedge clk or negedge w_rst_int_n) begin
    if (!w_rst_int_n) begin
      r_wdt_cnt <= '0;
    end else if ((r_state != RUN) || !wdt_en || wdt_kick || w_evt) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + WDT_CNT_W'(1);
    end
  end

  assign rst_out_n = r_rst_out_n;
  assign rst_cause = r_cause;
  assign wdt_cnt   = r_wdt_cnt;

endmodule
